bluetooth_tx: RTL and testbench
===============================

# bluetooth_tx

UART transmitter for the Bluetooth serial link: the transmit-side counterpart of the `Bluetooth` receiver. It accepts bytes from game logic (score reports, song-select acknowledgements) through a valid/ready handshake, buffers them in a 4-entry FIFO, and serialises them on `txd` as 8N1 frames at the same baud rate the receiver uses (10417 clocks per bit at 100 MHz, 9600 baud).

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per serial bit; must be at least 2.
- `FIFO_DEPTH`, default 4: byte buffer depth; must be a power of two, at least 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; one clock domain.
- `data`  in  8  byte to send.
- `valid`  in  1  `data` is offered this cycle.
- `ready`  out  1  FIFO can accept a byte; a byte transfers on each edge where `valid && ready`.
- `txd`  out  1  serial line to the Bluetooth module; idles high.
- `busy`  out  1  a frame is in progress or the FIFO is non-empty.

## Operation
- FIFO: `ready = !full`, combinational from registered pointers only; it does not depend on `valid`.
  - A write is ignored when full.
  - A read happens only from IDLE when the FIFO is non-empty.
  - A write and a read in the same cycle are both performed; the count is unchanged.
  - Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit for full/empty detection, and wrap modulo depth.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: if the FIFO is non-empty, pop into shift register `sh`, clear the bit counter and baud counter, and go to START.
  - START: `txd=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `txd=sh[0]`, LSB first; each bit lasts CLKS_PER_BIT cycles and `sh` shifts right; after bit 7 go to PARITY if enabled, else STOP.
  - PARITY: `txd` = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - STOP: `txd=1` for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1; the bit boundary is at terminal count. Its width is `$clog2(CLKS_PER_BIT)`.
- `txd` is a register driven from the next-state value, so the line has no glitches.
- `busy = (state != IDLE) || !empty`.

## Timing
- Reset values: `txd=1`, `ready=1`, `busy=0`, state IDLE, FIFO empty, counters 0. Reset asserted mid-frame forces `txd` high immediately and discards the frame and the FIFO contents.
- Byte accepted at edge N into an empty FIFO with FSM in IDLE:
  - edge N+1: pop, `txd` falls.
  - edge N+1+k·CLKS_PER_BIT: start of bit k, where start=0, data=1..8, stop=9.
- Frame length is 10·CLKS_PER_BIT cycles, or 11 with parity.
- Back-to-back frames: after the stop bit ends, FSM spends exactly one cycle in IDLE (`txd=1`), then pops the next byte. Inter-frame gap is CLKS_PER_BIT+1 cycles of high level, counting the stop bit.
- `ready` deasserts on the edge that makes the count equal FIFO_DEPTH. It reasserts on the edge of the next pop.

## Configuration
- `BLUETOOTH_TX_PARITY_EN` defined: the PARITY state is compiled in and frames are 8E1 (11 bits).
- Undefined: no PARITY state and no parity logic; frames are 8N1 (10 bits). This is the default and matches the current receiver.

## Structure
- Shared package `bluetooth_pkg`: FSM state enum `bt_tx_state_t`, constant `BT_CLKS_PER_BIT = 10417`, constant `BT_DATA_BITS = 8`. The receiver reuses the two constants.
- One sub-module, `bt_tx_fifo`: synchronous FIFO with parameter DEPTH, ports `clk`, `rst`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`. Data is valid the same cycle `rd_en` is asserted (show-ahead).
- The FSM and baud counter live in `bluetooth_tx`.

## Test plan
Bench uses CLKS_PER_BIT=8 and FIFO_DEPTH=4.
- Send one byte 0x55 after reset → `txd` sequence 0,1,0,1,0,1,0,1,0,1, each level 8 cycles, start edge 1 cycle after the handshake; `busy` high for 81 cycles.
- Hold `valid` with 0xA3,0x00,0xFF,0x3C,0x81 → five frames decode in order; exactly 9 high cycles between consecutive frames; `ready` low only while 4 entries are held.
- Hold `valid` high with FSM stalled mid-frame and the FIFO filled → `ready`=0 at count 4; a byte offered while `ready`=0 is never transmitted.
- Assert `rst` for 1 cycle during data bit 3 of 0xF0 with 2 bytes queued → `txd`=1 in the same cycle, `busy`=0, nothing more is sent; a new byte 0x12 afterwards is sent correctly.
- With `BLUETOOTH_TX_PARITY_EN`: bytes 0x07 and 0x03 → parity bits 1 and 0; frame length 88 cycles.

Source files
------------

// File: rtl/bluetooth_pkg.sv
// Shared definitions for the Bluetooth serial link (transmitter and receiver).
// The transmitter FSM has a PARITY state only when BLUETOOTH_TX_PARITY_EN is defined.
package bluetooth_pkg;

  localparam int BT_CLKS_PER_BIT = 10417;  // 9600 baud at 100 MHz
  localparam int BT_DATA_BITS    = 8;

  typedef enum logic [2:0] {
    BT_TX_IDLE   = 3'd0,
    BT_TX_START  = 3'd1,
    BT_TX_DATA   = 3'd2,
`ifdef BLUETOOTH_TX_PARITY_EN
    BT_TX_PARITY = 3'd3,
`endif
    BT_TX_STOP   = 3'd4
  } bt_tx_state_t;

endpackage

// File: rtl/bt_tx_fifo.sv
// Small show-ahead synchronous FIFO for the transmitter byte queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bt_tx_fifo
  import bluetooth_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [BT_DATA_BITS-1:0] wr_data,
  input  logic                    rd_en,
  output logic [BT_DATA_BITS-1:0] rd_data,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wr_ptr;
  logic [AW:0]             rd_ptr;
  logic [BT_DATA_BITS-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update: writes dropped when full, reads dropped when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/bluetooth_tx.sv
// UART transmitter for the Bluetooth link: valid/ready byte input, 4-deep
// queue, 8N1 frames on txd (8E1 when BLUETOOTH_TX_PARITY_EN is defined).
// Handshake: a byte transfers on every rising edge where valid && ready;
// ready depends only on the queue pointers, never on valid.
module bluetooth_tx
  import bluetooth_pkg::*;
#(
  parameter int CLKS_PER_BIT = BT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BT_DATA_BITS);

  bt_tx_state_t            state;
  logic [CW-1:0]           baud_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BT_DATA_BITS-1:0] sh;
  logic                    baud_tc;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_rd;
  logic [BT_DATA_BITS-1:0] fifo_rd_data;
`ifdef BLUETOOTH_TX_PARITY_EN
  logic                    par;
`endif

  assign baud_tc   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign fifo_rd   = (state == BT_TX_IDLE) && !fifo_empty;
  assign ready     = !fifo_full;
  assign busy      = (state != BT_TX_IDLE) || !fifo_empty;
  assign dbg_state = state;

  bt_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (valid),
    .wr_data (data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencer; txd is loaded with the level of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= BT_TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      txd      <= 1'b1;
`ifdef BLUETOOTH_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        BT_TX_IDLE: begin
          if (!fifo_empty) begin
            sh       <= fifo_rd_data;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            txd      <= 1'b0;
            state    <= BT_TX_START;
`ifdef BLUETOOTH_TX_PARITY_EN
            par      <= ^fifo_rd_data;
`endif
          end
        end
        BT_TX_START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            txd      <= sh[0];
            state    <= BT_TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BT_TX_DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            sh       <= {1'b0, sh[BT_DATA_BITS-1:1]};
            if (bit_cnt == BW'(BT_DATA_BITS - 1)) begin
`ifdef BLUETOOTH_TX_PARITY_EN
              txd   <= par;
              state <= BT_TX_PARITY;
`else
              txd   <= 1'b1;
              state <= BT_TX_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= sh[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef BLUETOOTH_TX_PARITY_EN
        BT_TX_PARITY: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            state    <= BT_TX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        BT_TX_STOP: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            state    <= BT_TX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
          txd      <= 1'b1;
          state    <= BT_TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Bench for bluetooth_tx with CLKS_PER_BIT=8, FIFO_DEPTH=4.
// Reference model: a byte queue plus a "position within frame" counter; the
// expected line level is the frame bit at position/CLKS_PER_BIT.
module tb_bluetooth_tx;

  localparam int C     = 8;
  localparam int DEPTH = 4;
`ifdef BLUETOOTH_TX_PARITY_EN
  localparam int NB    = 11;
`else
  localparam int NB    = 10;
`endif
  localparam int FLEN  = NB * C;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       txd;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  bluetooth_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .txd       (txd),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  bit         m_in  = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_acc;
  int         n_acc = 0;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef BLUETOOTH_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_in  = 1'b0;
      m_pos = 0;
    end else begin
      m_acc = (valid === 1'b1) && (m_fifo.size() < DEPTH);
      if (m_in) begin
        m_pos++;
        if (m_pos == FLEN) m_in = 1'b0;
      end else if (m_fifo.size() > 0) begin
        m_cur = m_fifo.pop_front();
        m_in  = 1'b1;
        m_pos = 0;
      end
      if (m_acc) begin
        m_fifo.push_back(data);
        exp_q.push_back(data);
        n_acc++;
      end
    end
  end

  // Cycle compare of all outputs against the model.
  always @(negedge clk) begin
    check("txd",   txd,   m_in ? frame_bit(m_cur, m_pos / C) : 1'b1);
    check("busy",  busy,  m_in || (m_fifo.size() > 0));
    check("ready", ready, m_fifo.size() < DEPTH);
  end

  // ---------------- line decoder / scoreboard ----------------
  bit         mon_in  = 1'b0;
  int         mon_cnt = 0;
  int         hi_run  = 0;
  int         n_starts = 0;
  int         n_rx = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_log[$];
  int         gap_q[$];
  logic       last_par = 1'b0;
  logic [7:0] exp_b;
  int         busy_run = 0;
  int         last_busy_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_in  = 1'b0;
      mon_cnt = 0;
      hi_run  = 0;
    end else if (!mon_in) begin
      if (txd === 1'b0) begin
        gap_q.push_back(hi_run);
        n_starts++;
        mon_in  = 1'b1;
        mon_cnt = 0;
      end else begin
        hi_run++;
      end
    end else begin
      mon_cnt++;
      if ((mon_cnt % C) == C / 2 && mon_cnt / C >= 1 && mon_cnt / C <= 8)
        rx_byte[mon_cnt / C - 1] = txd;
`ifdef BLUETOOTH_TX_PARITY_EN
      if (mon_cnt == 9 * C + C / 2) begin
        last_par = txd;
        check("rx_parity", last_par, ^rx_byte);
      end
`endif
      if (mon_cnt == (NB - 1) * C) begin
        mon_in = 1'b0;
        hi_run = 1;
        n_rx++;
        rx_log.push_back(rx_byte);
        exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("rx_byte", rx_byte, exp_b);
      end
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busy_run++;
    else begin
      if (busy_run > 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    logic acc;
    int   g;
    g     = 0;
    valid = 1'b1;
    data  = b;
    forever begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #2;
      if (acc === 1'b1) break;
      g++;
      if (g > 5000) begin
        tests++;
        fails++;
        $display("FAIL push_timeout: ready stayed %b, required 1", ready);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (busy !== 1'b0 && g < 20000);
    check("wait_idle_busy", busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] burst[5];
  int         g0, r0, a0, s0, gw;

  initial begin
    burst[0] = 8'hA3; burst[1] = 8'h00; burst[2] = 8'hFF;
    burst[3] = 8'h3C; burst[4] = 8'h81;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd",   txd,       1'b1);
    check("rst_ready", ready,     1'b1);
    check("rst_busy",  busy,      1'b0);
    check("rst_state", dbg_state, 3'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) @(posedge clk); #2;

    // Single byte 0x55
    push_byte(8'h55);
    valid = 1'b0;
    @(negedge clk);
    check("t1_txd_hold", txd, 1'b1);
    @(negedge clk);
    check("t1_txd_fall", txd, 1'b0);
    wait_idle();
    @(negedge clk);
    check("t1_busy_len", last_busy_run, 32'd81);
    check("t1_rx", rx_log[rx_log.size()-1], 8'h55);

    // Back-to-back burst with valid held
    @(posedge clk); #2;
    g0 = gap_q.size();
    r0 = rx_log.size();
    for (int i = 0; i < 5; i++) push_byte(burst[i]);
    valid = 1'b0;
    wait_idle();
    @(negedge clk);
    for (int i = 1; i < 5; i++) check("t2_gap", gap_q[g0+i], 32'd9);
    for (int i = 0; i < 5; i++) check("t2_order", rx_log[r0+i], burst[i]);

    // Fill the queue while a frame is running; overflow bytes are dropped
    @(posedge clk); #2;
    r0 = rx_log.size();
    a0 = n_acc;
    for (int i = 0; i < 60; i++) begin
      valid = 1'b1;
      data  = 8'($urandom_range(0, 255));
      @(posedge clk); #2;
    end
    @(negedge clk);
    check("t3_ready_full", ready, 1'b0);
    check("t3_model_cnt", m_fifo.size(), 32'd4);
    valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("t3_accepted", n_acc - a0, 32'd5);
    check("t3_sent", rx_log.size() - r0, 32'd5);

    // Reset during data bit 3 of 0xF0 with two bytes queued
    @(posedge clk); #2;
    push_byte(8'hF0);
    push_byte(8'h11);
    push_byte(8'h22);
    valid = 1'b0;
    gw = 0;
    do begin
      @(negedge clk);
      gw++;
    end while (!(mon_in && mon_cnt == 4 * C + 2) && gw < 2000);
    check("t4_reached_bit3", gw < 2000, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t4_txd_high", txd,   1'b1);
    check("t4_busy_low", busy,  1'b0);
    check("t4_ready",    ready, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    s0 = n_starts;
    repeat (200) @(negedge clk);
    check("t4_no_more_frames", n_starts - s0, 32'd0);
    @(posedge clk); #2;
    push_byte(8'h12);
    valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("t4_rx_12", rx_log[rx_log.size()-1], 8'h12);

    // Random traffic with random idle gaps
    for (int i = 0; i < 25; i++) begin
      push_byte(8'($urandom_range(0, 255)));
      valid = 1'b0;
      repeat ($urandom_range(0, 100)) @(posedge clk);
      #2;
    end
    wait_idle();
    @(negedge clk);
    check("t5_all_sent", exp_q.size(), 32'd0);

`ifdef BLUETOOTH_TX_PARITY_EN
    @(posedge clk); #2;
    push_byte(8'h07);
    valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("t6_par_07", last_par, 1'b1);
    check("t6_busy_len", last_busy_run, 32'd89);
    @(posedge clk); #2;
    push_byte(8'h03);
    valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("t6_par_03", last_par, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
